// File: rtl/mrcs_test_observer.sv
// Observer for the unclocked MRCS latch test cell: synchronises its outputs, counts
// edge-detector pulses, tracks sticky changes, and serves one view per req/ack readout.
`timescale 1ns/1ps
module mrcs_test_observer #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] obs_in,
  input  logic [1:0] sel,
  input  logic       req,
  input  logic       ack,
  output logic [7:0] dout,
  output logic       valid,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, CAPT, PRES, CLR} state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e                          state_q, state_d;
  logic [SYNC_STAGES-1:0][7:0]     sync_q;
  logic [7:0]                      s_prev_q;
  logic                            tog_q;
  logic [SYNC_STAGES-1:0]          tog_sync_q;
  logic                            tog_prev_q;
  logic [CNT_W-1:0]                cnt_q, cnt_d;
  logic [7:0]                      chg_q, chg_d;
  logic [7:0]                      hold_q, hold_d;
  logic [1:0]                      sel_q, sel_d;
  logic                            armed_q, armed_d;

  logic       pulse_in;
  logic [7:0] s;
  logic       tog_s;
  logic       pulse;
  logic [7:0] chg_set;
  logic [7:0] cnt_ext;
  logic [7:0] view;

  assign pulse_in = obs_in[7];
  assign s        = sync_q[SYNC_STAGES-1];
  assign tog_s    = tog_sync_q[SYNC_STAGES-1];
  assign pulse    = tog_s ^ tog_prev_q;
  assign chg_set  = s ^ s_prev_q;

  // Pulses may be narrower than a clk period, so each rising edge flips a toggle
  // that is then synchronised; every change of the synchronised toggle is one pulse.
  always_ff @(posedge pulse_in or negedge rst_n) begin
    if (!rst_n) tog_q <= 1'b0;
    else        tog_q <= ~tog_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q     <= '0;
      s_prev_q   <= '0;
      tog_sync_q <= '0;
      tog_prev_q <= 1'b0;
    end else begin
      sync_q[0] <= obs_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      tog_sync_q <= {tog_sync_q[SYNC_STAGES-2:0], tog_q};
      s_prev_q   <= s;
      tog_prev_q <= tog_s;
    end
  end

  always_comb begin
    cnt_ext = '0;
    cnt_ext[CNT_W-1:0] = cnt_q;
  end

  always_comb begin
    case (sel_q)
      2'd0:    view = s;
      2'd1:    view = chg_q;
      2'd2:    view = cnt_ext;
      default: view = s;
    endcase
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    hold_d  = hold_q;
    armed_d = armed_q | ~req;
    chg_d   = chg_q | chg_set;
    cnt_d   = cnt_q;
    if (pulse && cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
    case (state_q)
      IDLE: begin
        if (req && armed_q) begin
          state_d = CAPT;
          sel_d   = sel;
          armed_d = 1'b0;
        end
      end
      CAPT: begin
        hold_d  = view;
        state_d = PRES;
      end
      PRES: begin
        if (ack) state_d = CLR;
      end
      CLR: begin
        // New sets and new pulses in the clearing cycle survive the clear.
        if (sel_q == 2'd1) chg_d = (chg_q & ~hold_q) | chg_set;
        if (sel_q == 2'd2) cnt_d = pulse ? CNT_W'(1) : '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= 2'd0;
      hold_q  <= 8'h00;
      armed_q <= 1'b1;
      chg_q   <= 8'h00;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      hold_q  <= hold_d;
      armed_q <= armed_d;
      chg_q   <= chg_d;
      cnt_q   <= cnt_d;
    end
  end

  assign valid = (state_q == PRES);
  assign busy  = (state_q != IDLE);
  assign dout  = valid ? hold_q : 8'h00;

endmodule

// File: tb/tb_mrcs_test_observer.sv
// Scoreboard bench for mrcs_test_observer: expected views are queued at request time
// and compared when valid is presented.
`timescale 1ns/1ps
module tb_mrcs_test_observer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] obs_in;
  logic [1:0] sel;
  logic       req;
  logic       ack;
  logic [7:0] dout;
  logic       valid;
  logic       busy;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] exp_q[$];

  mrcs_test_observer #(.SYNC_STAGES(2), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .obs_in(obs_in), .sel(sel), .req(req), .ack(ack),
    .dout(dout), .valid(valid), .busy(busy)
  );

  always #5 clk = ~clk;

  // mode: 0 = read and ack, 1 = flip obs_in[0] so its change lands on the CLR clk,
  // 2 = leave the view presented without ack.
  task automatic do_read(input logic [1:0] s, input logic [7:0] exp, input int mode, input string name);
    int cyc;
    logic [7:0] e;
    exp_q.push_back(exp);
    sel = s;
    req = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) req = 1'b0;
    end while (!valid && cyc < 20);
    n_cmp++;
    if (valid !== 1'b1) begin
      n_bad++;
      $display("FAIL %s_timeout: valid=%b after %0d clks, required 1", name, valid, cyc);
      void'(exp_q.pop_front());
      return;
    end
    n_cmp++;
    if (cyc !== 2) begin
      n_bad++;
      $display("FAIL %s_latency: req->valid %0d clks, required 2", name, cyc);
    end
    e = exp_q.pop_front();
    n_cmp++;
    if (dout !== e) begin
      n_bad++;
      $display("FAIL %s_dout: got %h, required %h", name, dout, e);
    end
    if (mode == 2) return;
    if (mode == 1) begin
      obs_in[0] = ~obs_in[0];
      @(negedge clk);
    end
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || valid !== 1'b0) begin
      n_bad++;
      $display("FAIL %s_idle: busy=%b valid=%b, required 0 0", name, busy, valid);
    end
  endtask

  task automatic pulse(input int gap);
    @(negedge clk);
    #1 obs_in[7] = 1'b1;
    #2 obs_in[7] = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; obs_in = 8'h00; sel = 2'd0; req = 1'b0; ack = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (dout !== 8'h00 || valid !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_init: dout=%h valid=%b busy=%b, required 00 0 0", dout, valid, busy);
    end
    rst_n = 1'b1;
    @(negedge clk);
    obs_in = 8'hA5;  // rising bit 7 also counts one pulse
    repeat (4) @(negedge clk);
    do_read(2'd0, 8'hA5, 2, "reset_pres");
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (dout !== 8'h00) begin n_bad++; $display("FAIL reset_dout: got %h, required 00", dout); end
    n_cmp++;
    if (valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b, required 0", valid); end
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b, required 0", busy); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    do_read(2'd2, 8'h00, 0, "reset_cnt");
    do_read(2'd1, 8'hA5, 0, "reset_chg");
  endtask

  task automatic test_live();
    obs_in = 8'h3C;
    repeat (4) @(negedge clk);
    do_read(2'd0, 8'h3C, 0, "live");
    do_read(2'd3, 8'h3C, 0, "snapshot");
    do_read(2'd1, 8'hA5 ^ 8'h3C, 0, "live_chg");
  endtask

  task automatic test_sticky();
    obs_in = 8'h38;
    repeat (4) @(negedge clk);
    obs_in = 8'h3C;
    repeat (4) @(negedge clk);
    do_read(2'd1, 8'h04, 0, "sticky_first");
    do_read(2'd1, 8'h00, 0, "sticky_second");
  endtask

  task automatic test_pulse();
    for (int i = 0; i < 5; i++) pulse(10);
    do_read(2'd2, 8'h05, 0, "pulse_cnt");
    do_read(2'd2, 8'h00, 0, "pulse_cleared");
    do_read(2'd1, 8'h00, 0, "pulse_no_chg");
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 300; i++) pulse(4);
    repeat (4) @(negedge clk);
    do_read(2'd2, 8'hFF, 0, "saturate");
    do_read(2'd2, 8'h00, 0, "saturate_cleared");
  endtask

  task automatic test_collision();
    obs_in[0] = 1'b1;
    repeat (4) @(negedge clk);
    do_read(2'd1, 8'h01, 1, "collide_first");
    do_read(2'd1, 8'h01, 0, "collide_kept");
    do_read(2'd1, 8'h00, 0, "collide_cleared");
  endtask

  task automatic test_back_to_back();
    obs_in = 8'h5A;
    repeat (4) @(negedge clk);
    do_read(2'd0, 8'h5A, 0, "b2b_a");
    obs_in = 8'h66;
    repeat (4) @(negedge clk);
    do_read(2'd3, 8'h66, 0, "b2b_b");
  endtask

  initial begin
    test_reset();
    test_live();
    test_sticky();
    test_pulse();
    test_saturation();
    test_collision();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
